dac_stream_ctrl: RTL and testbench
==================================

Name: dac_stream_ctrl

Overview:
Sample-pacing controller for the board's 10-bit parallel DAC. It sits between the PLB DAC peripheral's sample source (FIFO or register, valid/ready) and the DAC pins. It sequences power-down and wake-up, issues one sample per programmable period with a DCLKIO strobe, and reports underruns and the sample count back to software-visible status.

Parameters:
DATA_W, 10, DAC sample width
DIV_W, 16, width of sample-period divider
WAKE_CYCLES, 1000, clocks held after PWRDN deassert before first sample (>=1)
PIN_MD, 1, static level driven on S_PinMD
CLK_MD, 0, static level driven on S_ClkMD

Ports:
Bus2IP_Clk  in  1  system clock; all logic on rising edge
Bus2IP_Reset  in  1  synchronous, active-high reset
ctrl_enable  in  1  run request (level)
ctrl_div  in  DIV_W  sample period minus one; period P = max(ctrl_div,3)+1 clocks
ctrl_format  in  1  DAC data format select, forwarded to S_Format
clr_underrun  in  1  one-cycle pulse, clears stat_underrun
s_data  in  DATA_W  next sample
s_valid  in  1  s_data valid
s_ready  out  1  block accepts s_data this cycle
S_Data  out  DATA_W  DAC data bus
S_DCLKIO  out  1  DAC latch clock; DAC latches on rising edge
S_PWRDN  out  1  DAC power-down, 1 = powered down
S_PinMD  out  1  static = PIN_MD
S_ClkMD  out  1  static = CLK_MD
S_Format  out  1  format latched in OFF
stat_running  out  1  1 in RUN/DRAIN
stat_underrun  out  1  sticky underrun flag
stat_count  out  16  samples issued, wraps at 65535->0

Behaviour:
- Reset values: S_Data=0, S_DCLKIO=0, S_PWRDN=1, S_Format=0, s_ready=0, stat_running=0, stat_underrun=0, stat_count=0, state=OFF, hold register empty. All outputs registered. Reset mid-operation aborts immediately to these values.
- Hold register: one-entry buffer. s_ready = (state in WAKE/RUN) and hold empty. Transfer on s_valid & s_ready. A fill and a drain in the same cycle are impossible, because ready requires empty.
- OFF: S_PWRDN=1, S_DCLKIO=0, S_Data=0; S_Format<=ctrl_format every cycle; ctrl_enable=1 -> WAKE.
- WAKE: S_PWRDN=0; wake counter runs 0..WAKE_CYCLES-1; hold may prefill. At terminal count -> RUN with phase counter cnt=0. ctrl_enable=0 -> OFF next cycle; hold flushed.
- RUN: cnt counts 0..P-1 and wraps. P is latched at RUN entry and at each wrap (cnt==P-1), so mid-period ctrl_div changes take effect at the next period.
- At cnt==0: if hold full, S_Data<=hold, hold emptied, stat_count+1. Otherwise S_Data holds its previous value and stat_underrun<=1, with no count increment.
- S_DCLKIO=1 for 1<=cnt<=floor(P/2), else 0. This gives >=1 clock of data setup before the rising edge.
- ctrl_enable=0 in RUN -> DRAIN. DRAIN completes the current period: DCLKIO pattern continues and no new sample is loaded. At cnt==P-1 -> OFF. Hold is flushed and s_ready=0 in DRAIN.
- clr_underrun clears stat_underrun. If a clear and a new underrun occur in the same cycle, set wins.
- ctrl_format changes outside OFF are ignored.

Test Plan:
- Reset then idle, WAKE_CYCLES=4: all outputs at reset values; S_PWRDN=1; s_ready=0 for 20 clocks.
- ctrl_div=3, enable, stream 0x001,0x002,0x3FF with s_valid always high: PWRDN falls 1 clock after enable. First S_Data=0x001 appears 4 clocks after PWRDN falls. DCLKIO pattern per 4-clock period is 0,1,1,0. Samples advance every 4 clocks; stat_count=3.
- ctrl_div=1 (clamped): period is 4 clocks, identical to the ctrl_div=3 case.
- Underrun: ctrl_div=7, provide one sample then withhold s_valid. S_Data holds that sample; stat_underrun=1 at the next cnt==0 and stat_count stays 1. Pulse clr_underrun -> 0. If the underrun repeats in the clear cycle -> stays 1.
- ctrl_div changed from 7 to 15 at cnt==3: current period finishes at 8 clocks; next period is 16 clocks.
- Deassert enable at cnt==2 of an 8-clock period: DCLKIO completes its pattern; OFF entered after cnt==7; S_PWRDN=1, S_Data=0. Assert Bus2IP_Reset mid-RUN -> reset values next clock.

Source files
------------

// File: rtl/dac_stream_ctrl.sv
// dac_stream_ctrl
//   Sample-pacing controller for the 10-bit parallel DAC. Sequences DAC
//   power-down/wake-up, issues one sample per programmable period with a
//   DCLKIO strobe, and reports underruns and the issued-sample count.
//
// Ports:
//   Bus2IP_Clk     system clock, all logic on rising edge
//   Bus2IP_Reset   synchronous active-high reset
//   ctrl_enable    run request (level)
//   ctrl_div       sample period minus one; period = max(ctrl_div,3)+1
//   ctrl_format    DAC data format, captured only while OFF
//   clr_underrun   one-cycle pulse clearing stat_underrun
//   s_data/s_valid/s_ready  sample source handshake
//   S_Data, S_DCLKIO, S_PWRDN, S_PinMD, S_ClkMD, S_Format  DAC pins
//   stat_running   high in RUN/DRAIN
//   stat_underrun  sticky underrun flag
//   stat_count     samples issued (wraps)
module dac_stream_ctrl #(
    parameter int unsigned DATA_W      = 10,
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned WAKE_CYCLES = 1000,
    parameter bit          PIN_MD      = 1'b1,
    parameter bit          CLK_MD      = 1'b0
) (
    input  logic              Bus2IP_Clk,
    input  logic              Bus2IP_Reset,
    input  logic              ctrl_enable,
    input  logic [DIV_W-1:0]  ctrl_div,
    input  logic              ctrl_format,
    input  logic              clr_underrun,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] S_Data,
    output logic              S_DCLKIO,
    output logic              S_PWRDN,
    output logic              S_PinMD,
    output logic              S_ClkMD,
    output logic              S_Format,
    output logic              stat_running,
    output logic              stat_underrun,
    output logic [15:0]       stat_count
);

    localparam int unsigned       WAKE_W    = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
    localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);
    localparam logic [DIV_W-1:0]  DIV_MIN   = DIV_W'(3);

    typedef enum logic [1:0] {
        OFF,
        WAKE,
        RUN,
        DRAIN
    } state_t;

    state_t              state, state_n;
    logic [WAKE_W-1:0]   wake_cnt, wake_n;
    logic [DIV_W-1:0]    cnt, cnt_n;
    logic [DIV_W-1:0]    per_m1, per_n;
    logic [DATA_W-1:0]   hold_data, hold_data_n;
    logic                hold_full, hold_full_n;
    logic [DATA_W-1:0]   data_n;
    logic [15:0]         count_n;
    logic                underrun_n;
    logic                ready_n;
    logic                dclk_n;
    logic                load;
    logic [DIV_W-1:0]    div_clamped;
    logic [DIV_W:0]      half_per;

    assign S_PinMD     = PIN_MD;
    assign S_ClkMD     = CLK_MD;
    assign div_clamped = (ctrl_div < DIV_MIN) ? DIV_MIN : ctrl_div;

    // Outputs are registered from the next-cycle state so that the pins in
    // the cycle where cnt==c already reflect phase c (sample lands with cnt==0).
    always_comb begin
        state_n     = state;
        wake_n      = wake_cnt;
        cnt_n       = cnt;
        per_n       = per_m1;
        hold_data_n = hold_data;
        hold_full_n = hold_full;
        data_n      = S_Data;
        count_n     = stat_count;
        underrun_n  = stat_underrun;
        load        = 1'b0;

        if (clr_underrun)
            underrun_n = 1'b0;

        if (s_valid && s_ready) begin
            hold_data_n = s_data;
            hold_full_n = 1'b1;
        end

        case (state)
            OFF: begin
                wake_n = '0;
                if (ctrl_enable)
                    state_n = WAKE;
            end
            WAKE: begin
                if (!ctrl_enable) begin
                    state_n = OFF;
                end else if (wake_cnt == WAKE_LAST) begin
                    state_n = RUN;
                    cnt_n   = '0;
                    per_n   = div_clamped;
                    load    = 1'b1;
                end else begin
                    wake_n = wake_cnt + 1'b1;
                end
            end
            RUN: begin
                if (cnt == per_m1) begin
                    cnt_n = '0;
                    per_n = div_clamped;
                    // Disable landing exactly on the wrap ends the period here.
                    if (!ctrl_enable)
                        state_n = OFF;
                    else
                        load = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                    if (!ctrl_enable)
                        state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (cnt == per_m1)
                    state_n = OFF;
                else
                    cnt_n = cnt + 1'b1;
            end
            default: state_n = OFF;
        endcase

        // Underrun set is applied after the clear so set wins.
        if (load) begin
            if (hold_full) begin
                data_n      = hold_data;
                hold_full_n = 1'b0;
                count_n     = stat_count + 16'd1;
            end else begin
                underrun_n = 1'b1;
            end
        end

        if (state_n == OFF || state_n == DRAIN)
            hold_full_n = 1'b0;
        if (state_n == OFF)
            data_n = '0;

        ready_n  = (state_n == WAKE || state_n == RUN) && !hold_full_n;
        half_per = ({1'b0, per_n} + 1'b1) >> 1;
        dclk_n   = (state_n == RUN || state_n == DRAIN) && (cnt_n != '0)
                   && ({1'b0, cnt_n} <= half_per);
    end

    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            state         <= OFF;
            wake_cnt      <= '0;
            cnt           <= '0;
            per_m1        <= DIV_MIN;
            hold_data     <= '0;
            hold_full     <= 1'b0;
            S_Data        <= '0;
            S_DCLKIO      <= 1'b0;
            S_PWRDN       <= 1'b1;
            S_Format      <= 1'b0;
            s_ready       <= 1'b0;
            stat_running  <= 1'b0;
            stat_underrun <= 1'b0;
            stat_count    <= '0;
        end else begin
            state         <= state_n;
            wake_cnt      <= wake_n;
            cnt           <= cnt_n;
            per_m1        <= per_n;
            hold_data     <= hold_data_n;
            hold_full     <= hold_full_n;
            S_Data        <= data_n;
            S_DCLKIO      <= dclk_n;
            S_PWRDN       <= (state_n == OFF);
            s_ready       <= ready_n;
            stat_running  <= (state_n == RUN || state_n == DRAIN);
            stat_underrun <= underrun_n;
            stat_count    <= count_n;
            if (state == OFF)
                S_Format <= ctrl_format;
        end
    end

endmodule

// File: tb/tb_dac_stream_ctrl.sv
// tb_dac_stream_ctrl
//   Directed bench for dac_stream_ctrl with WAKE_CYCLES=4. Accepted samples
//   are queued as expected DAC words and compared whenever stat_count moves.
module tb_dac_stream_ctrl;

    localparam int unsigned DATA_W = 10;
    localparam int unsigned DIV_W  = 16;

    logic              Bus2IP_Clk = 1'b0;
    logic              Bus2IP_Reset;
    logic              ctrl_enable;
    logic [DIV_W-1:0]  ctrl_div;
    logic              ctrl_format;
    logic              clr_underrun;
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] S_Data;
    logic              S_DCLKIO;
    logic              S_PWRDN;
    logic              S_PinMD;
    logic              S_ClkMD;
    logic              S_Format;
    logic              stat_running;
    logic              stat_underrun;
    logic [15:0]       stat_count;

    always #5 Bus2IP_Clk = ~Bus2IP_Clk;

    dac_stream_ctrl #(
        .DATA_W      (DATA_W),
        .DIV_W       (DIV_W),
        .WAKE_CYCLES (4),
        .PIN_MD      (1'b1),
        .CLK_MD      (1'b0)
    ) dut (
        .Bus2IP_Clk    (Bus2IP_Clk),
        .Bus2IP_Reset  (Bus2IP_Reset),
        .ctrl_enable   (ctrl_enable),
        .ctrl_div      (ctrl_div),
        .ctrl_format   (ctrl_format),
        .clr_underrun  (clr_underrun),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .S_Data        (S_Data),
        .S_DCLKIO      (S_DCLKIO),
        .S_PWRDN       (S_PWRDN),
        .S_PinMD       (S_PinMD),
        .S_ClkMD       (S_ClkMD),
        .S_Format      (S_Format),
        .stat_running  (stat_running),
        .stat_underrun (stat_underrun),
        .stat_count    (stat_count)
    );

    logic [DATA_W-1:0] src_q[$];
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] exp_word;
    logic [15:0]       prev_count = '0;
    logic [3:0]        pat4 = 4'b0110;
    logic [4:0]        drain_pat = 5'b00011;
    int unsigned       n_checks = 0;
    int unsigned       n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_src();
        if (src_q.size() > 0) begin
            s_valid = 1'b1;
            s_data  = src_q[0];
        end else begin
            s_valid = 1'b0;
            s_data  = '0;
        end
    endtask

    // One clock: monitor at negedge, let the edge happen, drive at edge+1.
    task automatic tick();
        @(negedge Bus2IP_Clk);
        if (stat_count !== prev_count) begin
            prev_count = stat_count;
            if (exp_q.size() == 0) begin
                check("sb_pending", 32'(exp_q.size()), 32'd1);
            end else begin
                exp_word = exp_q.pop_front();
                check("sb_data", 32'(S_Data), 32'(exp_word));
            end
        end
        if (s_valid && s_ready) begin
            exp_q.push_back(s_data);
            void'(src_q.pop_front());
        end
        @(posedge Bus2IP_Clk);
        #1;
        drive_src();
    endtask

    task automatic ticks(input int unsigned n);
        for (int unsigned i = 0; i < n; i++)
            tick();
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_data"},     32'(S_Data),        32'd0);
        check({tag, "_dclk"},     32'(S_DCLKIO),      32'd0);
        check({tag, "_pwrdn"},    32'(S_PWRDN),       32'd1);
        check({tag, "_format"},   32'(S_Format),      32'd0);
        check({tag, "_ready"},    32'(s_ready),       32'd0);
        check({tag, "_running"},  32'(stat_running),  32'd0);
        check({tag, "_underrun"}, 32'(stat_underrun), 32'd0);
        check({tag, "_count"},    32'(stat_count),    32'd0);
    endtask

    task automatic check_off(input string tag);
        check({tag, "_pwrdn"},   32'(S_PWRDN),      32'd1);
        check({tag, "_data"},    32'(S_Data),       32'd0);
        check({tag, "_dclk"},    32'(S_DCLKIO),     32'd0);
        check({tag, "_running"}, 32'(stat_running), 32'd0);
        check({tag, "_ready"},   32'(s_ready),      32'd0);
    endtask

    task automatic pulse_clear();
        clr_underrun = 1'b1;
        tick();
        clr_underrun = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Bus2IP_Reset = 1'b1;
        ctrl_enable  = 1'b0;
        ctrl_div     = 16'd3;
        ctrl_format  = 1'b0;
        clr_underrun = 1'b0;
        s_valid      = 1'b0;
        s_data       = '0;

        // Reset and idle
        ticks(2);
        check_reset("rst");
        check("pin_md", 32'(S_PinMD), 32'd1);
        check("clk_md", 32'(S_ClkMD), 32'd0);
        Bus2IP_Reset = 1'b0;
        for (int unsigned i = 0; i < 20; i++) begin
            tick();
            check("idle_ready", 32'(s_ready), 32'd0);
            check("idle_pwrdn", 32'(S_PWRDN), 32'd1);
        end
        check("idle_running", 32'(stat_running), 32'd0);

        // Format captured while OFF
        ctrl_format = 1'b1;
        tick();
        check("format_off", 32'(S_Format), 32'd1);

        // Stream three samples, period 4
        src_q.push_back(10'h001);
        src_q.push_back(10'h002);
        src_q.push_back(10'h3FF);
        ctrl_enable = 1'b1;
        drive_src();
        tick();
        check("wake_pwrdn", 32'(S_PWRDN), 32'd0);
        check("wake_running", 32'(stat_running), 32'd0);
        ctrl_format = 1'b0;
        ticks(3);
        check("wake_data", 32'(S_Data), 32'd0);
        check("wake_ready_full", 32'(s_ready), 32'd0);
        tick();
        check("first_data", 32'(S_Data), 32'h001);
        check("first_count", 32'(stat_count), 32'd1);
        check("first_running", 32'(stat_running), 32'd1);
        for (int unsigned i = 0; i < 12; i++) begin
            check("p4_dclk", 32'(S_DCLKIO), 32'(pat4[i % 4]));
            tick();
        end
        check("p4_count", 32'(stat_count), 32'd3);
        check("p4_last_data", 32'(S_Data), 32'h3FF);
        check("p4_underrun", 32'(stat_underrun), 32'd1);
        check("format_ignored", 32'(S_Format), 32'd1);
        check("p4_sb_empty", 32'(exp_q.size()), 32'd0);
        ctrl_enable = 1'b0;
        ticks(4);
        check_off("p4_off");
        pulse_clear();
        check("clr_off", 32'(stat_underrun), 32'd0);

        // Clamped divider behaves like period 4
        ctrl_div = 16'd1;
        src_q.push_back(10'h155);
        src_q.push_back(10'h2AA);
        ctrl_enable = 1'b1;
        drive_src();
        tick();
        ticks(4);
        check("clamp_first", 32'(S_Data), 32'h155);
        for (int unsigned i = 0; i < 8; i++) begin
            check("clamp_dclk", 32'(S_DCLKIO), 32'(pat4[i % 4]));
            tick();
        end
        check("clamp_second", 32'(S_Data), 32'h2AA);
        check("clamp_count", 32'(stat_count), 32'd5);
        ctrl_enable = 1'b0;
        ticks(4);
        check_off("clamp_off");
        pulse_clear();

        // Underrun, clear, clear colliding with a new underrun
        ctrl_div = 16'd7;
        src_q.push_back(10'h0AB);
        ctrl_enable = 1'b1;
        drive_src();
        tick();
        ticks(4);
        check("ur_first", 32'(S_Data), 32'h0AB);
        check("ur_first_count", 32'(stat_count), 32'd6);
        ticks(8);
        check("ur_set", 32'(stat_underrun), 32'd1);
        check("ur_count_held", 32'(stat_count), 32'd6);
        check("ur_data_held", 32'(S_Data), 32'h0AB);
        pulse_clear();
        check("ur_cleared", 32'(stat_underrun), 32'd0);
        ticks(6);
        check("ur_still_clear", 32'(stat_underrun), 32'd0);
        pulse_clear();
        check("ur_set_wins", 32'(stat_underrun), 32'd1);

        // Divider change mid-period applies from the next period
        src_q.push_back(10'h1C3);
        drive_src();
        ticks(3);
        ctrl_div = 16'd15;
        ticks(4);
        check("div_old_end_dclk", 32'(S_DCLKIO), 32'd0);
        check("div_old_end_data", 32'(S_Data), 32'h0AB);
        tick();
        check("div_wrap8_data", 32'(S_Data), 32'h1C3);
        check("div_wrap8_count", 32'(stat_count), 32'd7);
        pulse_clear();
        check("div_clr", 32'(stat_underrun), 32'd0);
        check("div_cnt1_dclk", 32'(S_DCLKIO), 32'd1);
        ticks(7);
        check("div_cnt8_dclk", 32'(S_DCLKIO), 32'd1);
        check("div_cnt8_count", 32'(stat_count), 32'd7);
        tick();
        check("div_cnt9_dclk", 32'(S_DCLKIO), 32'd0);
        ticks(6);
        check("div_cnt15_underrun", 32'(stat_underrun), 32'd0);
        tick();
        check("div_wrap16_underrun", 32'(stat_underrun), 32'd1);
        check("div_wrap16_count", 32'(stat_count), 32'd7);

        // Drain: disable at cnt==2 of an 8-clock period
        ctrl_div = 16'd7;
        ticks(16);
        ticks(2);
        check("drain_cnt2_dclk", 32'(S_DCLKIO), 32'd1);
        ctrl_enable = 1'b0;
        for (int unsigned i = 0; i < 5; i++) begin
            tick();
            check("drain_dclk", 32'(S_DCLKIO), 32'(drain_pat[i]));
            check("drain_running", 32'(stat_running), 32'd1);
            check("drain_pwrdn", 32'(S_PWRDN), 32'd0);
            check("drain_ready", 32'(s_ready), 32'd0);
        end
        check("drain_data", 32'(S_Data), 32'h1C3);
        tick();
        check_off("drain_off");
        check("drain_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of RUN
        src_q.push_back(10'h321);
        src_q.push_back(10'h123);
        ctrl_format = 1'b1;
        ctrl_enable = 1'b1;
        drive_src();
        tick();
        ticks(4);
        check("mid_data", 32'(S_Data), 32'h321);
        check("mid_count", 32'(stat_count), 32'd8);
        check("mid_format", 32'(S_Format), 32'd1);
        ticks(2);
        check("mid_hold_full", 32'(s_ready), 32'd0);
        Bus2IP_Reset = 1'b1;
        ctrl_enable  = 1'b0;
        tick();
        prev_count = '0;
        exp_q.delete();
        src_q.delete();
        drive_src();
        check_reset("mid_rst");
        Bus2IP_Reset = 1'b0;
        ctrl_format  = 1'b0;
        ticks(3);
        check_off("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
